// File: rtl/systolic_feeder.sv
// Feeder for a 4x4 systolic array: buffers A columns and B rows over four load beats,
// then streams them skewed onto the west/north edges for ten cycles and waits for arr_done.
module systolic_feeder #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WIDTH-1:0] a_col,
  input  logic [4*WIDTH-1:0] b_row,
  input  logic               arr_done,
  output logic [WIDTH-1:0]   west0,
  output logic [WIDTH-1:0]   west1,
  output logic [WIDTH-1:0]   west2,
  output logic [WIDTH-1:0]   west3,
  output logic [WIDTH-1:0]   north0,
  output logic [WIDTH-1:0]   north1,
  output logic [WIDTH-1:0]   north2,
  output logic [WIDTH-1:0]   north3,
  output logic               cs,
  output logic               acc_clr,
  output logic               busy,
  output logic               mat_done
);

  localparam int N = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_STREAM,
    S_WAIT
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] t_q, t_d;
  logic [1:0] beat_q, beat_d;
  logic       accept;

  logic [WIDTH-1:0] a_q [N][N];
  logic [WIDTH-1:0] b_q [N][N];

  logic             in_ready_q, in_ready_d;
  logic             cs_q, cs_d;
  logic             acc_clr_q, acc_clr_d;
  logic             busy_q, busy_d;
  logic             mat_done_q, mat_done_d;
  logic [WIDTH-1:0] west_q [N];
  logic [WIDTH-1:0] west_d [N];
  logic [WIDTH-1:0] north_q [N];
  logic [WIDTH-1:0] north_d [N];

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    beat_d     = beat_q;
    mat_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_LOAD;
          beat_d  = 2'd1;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (beat_q == 2'd3) begin
            state_d = S_CLEAR;
            beat_d  = 2'd0;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_STREAM;
        t_d     = 4'd0;
      end
      S_STREAM: begin
        if (t_q == 4'd9) begin
          state_d = S_WAIT;
          t_d     = 4'd0;
        end else begin
          t_d = t_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (arr_done) begin
          state_d    = S_IDLE;
          mat_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they describe;
  // busy covers the mat_done cycle even though that cycle is already IDLE.
  always_comb begin
    in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    cs_d       = (state_d == S_STREAM);
    acc_clr_d  = (state_d == S_CLEAR);
    busy_d     = (state_d != S_IDLE) || mat_done_d;
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      west_d[i]  = '0;
      north_d[i] = '0;
      if ((state_d == S_STREAM) && (t_d >= 4'(i)) && ((t_d - 4'(i)) <= 4'd3)) begin
        west_d[i]  = a_q[2'(i)][2'(t_d - 4'(i))];
        north_d[i] = b_q[2'(t_d - 4'(i))][2'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      beat_q     <= '0;
      in_ready_q <= 1'b1;
      cs_q       <= 1'b0;
      acc_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      mat_done_q <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        west_q[i]  <= '0;
        north_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      beat_q     <= beat_d;
      in_ready_q <= in_ready_d;
      cs_q       <= cs_d;
      acc_clr_q  <= acc_clr_d;
      busy_q     <= busy_d;
      mat_done_q <= mat_done_d;
      for (int unsigned i = 0; i < N; i++) begin
        west_q[i]  <= west_d[i];
        north_q[i] <= north_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int unsigned i = 0; i < N; i++) begin
        a_q[2'(i)][beat_q] <= a_col[i*WIDTH +: WIDTH];
        b_q[beat_q][2'(i)] <= b_row[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = in_ready_q;
  assign cs       = cs_q;
  assign acc_clr  = acc_clr_q;
  assign busy     = busy_q;
  assign mat_done = mat_done_q;
  assign west0    = west_q[0];
  assign west1    = west_q[1];
  assign west2    = west_q[2];
  assign west3    = west_q[3];
  assign north0   = north_q[0];
  assign north1   = north_q[1];
  assign north2   = north_q[2];
  assign north3   = north_q[3];

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed/random bench for systolic_feeder: expected edge streams come from a wavefront model
// that places each matrix element at the cycle it should reach the array boundary.
module tb_systolic_feeder;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] a_col;
  logic [4*W-1:0] b_row;
  logic           arr_done;
  logic [W-1:0]   west0, west1, west2, west3;
  logic [W-1:0]   north0, north1, north2, north3;
  logic           cs, acc_clr, busy, mat_done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] ma [4][4];
  logic [W-1:0] mb [4][4];
  logic [W-1:0] exp_w [4][10];
  logic [W-1:0] exp_n [4][10];
  logic [W-1:0] w_out [4];
  logic [W-1:0] n_out [4];

  assign w_out[0] = west0;
  assign w_out[1] = west1;
  assign w_out[2] = west2;
  assign w_out[3] = west3;
  assign n_out[0] = north0;
  assign n_out[1] = north1;
  assign n_out[2] = north2;
  assign n_out[3] = north3;

  always #5 clk = ~clk;

  systolic_feeder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_col    (a_col),
    .b_row    (b_row),
    .arr_done (arr_done),
    .west0    (west0),
    .west1    (west1),
    .west2    (west2),
    .west3    (west3),
    .north0   (north0),
    .north1   (north1),
    .north2   (north2),
    .north3   (north3),
    .cs       (cs),
    .acc_clr  (acc_clr),
    .busy     (busy),
    .mat_done (mat_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Row i of A enters west i delayed by i cycles; column j of B enters north j delayed by j.
  task automatic build_model();
    for (int i = 0; i < 4; i++)
      for (int t = 0; t < 10; t++) begin
        exp_w[i][t] = '0;
        exp_n[i][t] = '0;
      end
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        exp_w[i][i + k] = ma[i][k];
        exp_n[i][k + i] = mb[k][i];
      end
  endtask

  task automatic rand_mats();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = $urandom();
        mb[i][k] = $urandom();
      end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " cs"}, 64'(cs), 64'd0);
    chk({tag, " acc_clr"}, 64'(acc_clr), 64'd0);
    chk({tag, " mat_done"}, 64'(mat_done), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s west%0d", tag, i), 64'(w_out[i]), 64'd0);
      chk($sformatf("%s north%0d", tag, i), 64'(n_out[i]), 64'd0);
    end
  endtask

  task automatic chk_stream_cycle(input string tag, input int t);
    chk($sformatf("%s cs t%0d", tag, t), 64'(cs), 64'd1);
    chk($sformatf("%s acc_clr t%0d", tag, t), 64'(acc_clr), 64'd0);
    chk($sformatf("%s busy t%0d", tag, t), 64'(busy), 64'd1);
    chk($sformatf("%s in_ready t%0d", tag, t), 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s west%0d t%0d", tag, i, t), 64'(w_out[i]), 64'(exp_w[i][t]));
      chk($sformatf("%s north%0d t%0d", tag, i, t), 64'(n_out[i]), 64'(exp_n[i][t]));
    end
  endtask

  // Four beats of ma/mb; optional idle cycle before beats 1..3 and a long pause before beat 2.
  task automatic load(input string tag, input bit gaps, input int pause);
    for (int k = 0; k < 4; k++) begin
      if (gaps && k > 0) begin
        in_valid = 1'b0;
        a_col    = {$urandom(), $urandom(), $urandom(), $urandom()};
        step();
        chk($sformatf("%s gap ready k%0d", tag, k), 64'(in_ready), 64'd1);
      end
      if (k == 2) begin
        for (int p = 0; p < pause; p++) begin
          in_valid = 1'b0;
          step();
          chk($sformatf("%s hold ready p%0d", tag, p), 64'(in_ready), 64'd1);
          chk($sformatf("%s hold cs p%0d", tag, p), 64'(cs), 64'd0);
        end
      end
      for (int i = 0; i < 4; i++) begin
        a_col[i*W +: W] = ma[i][k];
        b_row[i*W +: W] = mb[k][i];
      end
      in_valid = 1'b1;
      step();
      if (k < 3) chk($sformatf("%s busy after beat%0d", tag, k), 64'(busy), 64'd1);
    end
    in_valid = 1'b0;
    chk({tag, " clear acc_clr"}, 64'(acc_clr), 64'd1);
    chk({tag, " clear cs"}, 64'(cs), 64'd0);
    chk({tag, " clear in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, " clear busy"}, 64'(busy), 64'd1);
    chk({tag, " clear west0"}, 64'(west0), 64'd0);
  endtask

  // Called in the CLEAR cycle; returns in the mat_done cycle (btb) or one cycle after it.
  task automatic stream(input string tag, input bit junk, input bit done_early,
                        input int wait_cycles, input bit btb);
    step();
    if (done_early) arr_done = 1'b1;
    for (int t = 0; t < 10; t++) begin
      chk_stream_cycle(tag, t);
      if (junk) begin
        in_valid = 1'b1;
        a_col    = {$urandom(), $urandom(), $urandom(), $urandom()};
        b_row    = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (t == 9) begin
        arr_done = 1'b0;
        in_valid = 1'b0;
      end
      step();
    end
    for (int w = 0; w < wait_cycles; w++) begin
      chk($sformatf("%s wait cs w%0d", tag, w), 64'(cs), 64'd0);
      chk($sformatf("%s wait mat_done w%0d", tag, w), 64'(mat_done), 64'd0);
      chk($sformatf("%s wait busy w%0d", tag, w), 64'(busy), 64'd1);
      chk($sformatf("%s wait in_ready w%0d", tag, w), 64'(in_ready), 64'd0);
      chk($sformatf("%s wait west1 w%0d", tag, w), 64'(west1), 64'd0);
      chk($sformatf("%s wait north3 w%0d", tag, w), 64'(north3), 64'd0);
      step();
    end
    arr_done = 1'b1;
    step();
    arr_done = 1'b0;
    chk({tag, " mat_done pulse"}, 64'(mat_done), 64'd1);
    chk({tag, " done busy"}, 64'(busy), 64'd1);
    chk({tag, " done in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, " done cs"}, 64'(cs), 64'd0);
    if (!btb) begin
      step();
      chk({tag, " mat_done single"}, 64'(mat_done), 64'd0);
      chk({tag, " idle busy"}, 64'(busy), 64'd0);
      chk({tag, " idle in_ready"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    arr_done = 1'b0;
    a_col    = '0;
    b_row    = '0;
    step();
    step();
    rst = 1'b0;
    chk_idle_outputs("reset");
    arr_done = 1'b1;
    step();
    arr_done = 1'b0;
    chk_idle_outputs("idle arr_done ignored");

    // Identity A with B[k][j] = 4k+j+1
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = (i == k) ? 32'd1 : 32'd0;
        mb[i][k] = 32'(4 * i + k + 1);
      end
    build_model();
    load("ident", 1'b0, 0);
    stream("ident", 1'b0, 1'b0, 1, 1'b0);

    // Handshake gaps, long LOAD stall, junk during stream, arr_done during stream, late done
    rand_mats();
    build_model();
    load("gaps", 1'b1, 20);
    stream("gaps", 1'b1, 1'b1, 5, 1'b0);

    // Reset during a partial load, then reset mid-stream at t = 4
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a_col = {$urandom(), $urandom(), $urandom(), $urandom()};
      b_row = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_outputs("rst mid-load");
    rand_mats();
    build_model();
    load("rstA", 1'b0, 0);
    step();
    for (int t = 0; t < 4; t++) begin
      chk_stream_cycle("rstA", t);
      step();
    end
    chk_stream_cycle("rstA", 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_outputs("rst mid-stream");
    step();
    chk_idle_outputs("post rst idle");
    rand_mats();
    build_model();
    load("rstB", 1'b0, 0);
    stream("rstB", 1'b0, 1'b0, 2, 1'b0);

    // Back-to-back: matrix 2 beat 0 offered in the mat_done cycle
    rand_mats();
    build_model();
    load("btb1", 1'b0, 0);
    stream("btb1", 1'b0, 1'b0, 3, 1'b1);
    rand_mats();
    build_model();
    load("btb2", 1'b0, 0);
    stream("btb2", 1'b0, 1'b0, 1, 1'b0);

    // Extreme values
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = '1;
        mb[i][k] = '1;
      end
    build_model();
    load("ones", 1'b0, 0);
    stream("ones", 1'b0, 1'b0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
